sixteen_four_encoder: RTL



---
 rtl/sixteen_four_encoder_pkg.sv | 21 ++
 rtl/sixteen_four_encoder_if.sv | 24 ++
 rtl/sixteen_four_encoder_prio_encode16.sv | 38 +++
 rtl/sixteen_four_encoder.sv | 116 +++++++++++
 4 files changed

// File: rtl/sixteen_four_encoder_pkg.sv
// Shared constants, FSM state type and one-hot helper for the 16-to-4
// request encoder. Optional feature macro: SIXTEEN_FOUR_ROUND_ROBIN_EN.
package encoder_pkg;

   localparam int N_REQ = 16;
   localparam int IDX_W = 4;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_e;

   // Decoder-compatible one-hot form of an index.
   function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      logic [N_REQ-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/sixteen_four_encoder_if.sv
// Request / grant bundle of the 16-to-4 encoder.
// The master drives requests, mask and ack; the slave (encoder) presents the grant.
// Optional feature macro: SIXTEEN_FOUR_ROUND_ROBIN_EN.
interface sixteen_four_encoder_if;

   logic [encoder_pkg::N_REQ-1:0] req;
   logic [encoder_pkg::N_REQ-1:0] mask;
   logic                          ack;
   logic                          out_valid;
   logic [encoder_pkg::IDX_W-1:0] out_idx;
   logic [encoder_pkg::N_REQ-1:0] out_onehot;
   logic [encoder_pkg::N_REQ-1:0] pending;

   modport master (
      output req, mask, ack,
      input  out_valid, out_idx, out_onehot, pending
   );

   modport slave (
      input  req, mask, ack,
      output out_valid, out_idx, out_onehot, pending
   );

endinterface

// File: rtl/sixteen_four_encoder_prio_encode16.sv
// Combinational find-first-set over 16 lines, searching upward from a
// start offset and wrapping 15 -> 0. A zero offset gives fixed
// lowest-index-first priority.
// Optional feature macro: SIXTEEN_FOUR_ROUND_ROBIN_EN (drives start_i).
module prio_encode16
   import encoder_pkg::*;
(
   input  logic [N_REQ-1:0] vec_i,
   input  logic [IDX_W-1:0] start_i,
   output logic             found_o,
   output logic [IDX_W-1:0] idx_o
);

   logic [N_REQ-1:0] rot;
   logic [IDX_W-1:0] pos;

   // Rotate so that bit start_i lands at position 0; the 4-bit add wraps.
   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
         localparam logic [IDX_W-1:0] OFS = IDX_W'(gi);
         assign rot[gi] = vec_i[OFS + start_i];
      end
   endgenerate

   // Lowest set bit of the rotated vector, then undo the rotation.
   always_comb begin
      found_o = 1'b0;
      pos     = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            found_o = 1'b1;
            pos     = IDX_W'(i);
         end
      end
      idx_o = pos + start_i;
   end

endmodule

// File: rtl/sixteen_four_encoder.sv
// 16-to-4 registered request encoder: sticky pending register, masked
// priority selection and a valid/ack presentation handshake.
// Optional feature macro: SIXTEEN_FOUR_ROUND_ROBIN_EN -- when defined the
// search starts at a rotating pointer that moves past each acked index.
module sixteen_four_encoder
   import encoder_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   sixteen_four_encoder_if.slave bus
);

   state_e           state_q, state_d;
   logic [N_REQ-1:0] pending_q, pending_d;
   logic [IDX_W-1:0] out_idx_q, out_idx_d;
   logic [N_REQ-1:0] out_onehot_q, out_onehot_d;

   logic             out_valid;
   logic             take;
   logic [N_REQ-1:0] clr;
   logic [N_REQ-1:0] elig;
   logic [IDX_W-1:0] start;
   logic             found;
   logic [IDX_W-1:0] sel_idx;

   assign out_valid = (state_q == PRESENT);
   assign take      = bus.ack && out_valid;
   // out_onehot_q is the one-hot of out_idx_q whenever out_valid is set.
   assign clr       = take ? out_onehot_q : '0;
   // Registered pending only: a request becomes eligible one cycle later.
   assign elig      = pending_q & ~bus.mask;

`ifdef SIXTEEN_FOUR_ROUND_ROBIN_EN
   logic [IDX_W-1:0] ptr_q, ptr_d;

   // Move the search start just past the index being accepted.
   always_comb begin
      ptr_d = ptr_q;
      if (take) begin
         ptr_d = out_idx_q + 1'b1;
      end
   end

   // Rotation pointer register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign start = ptr_q;
`else
   assign start = '0;
`endif

   prio_encode16 u_prio (
      .vec_i   (elig),
      .start_i (start),
      .found_o (found),
      .idx_o   (sel_idx)
   );

   // Sticky pending: a new request on the bit being cleared keeps it set.
   always_comb begin
      pending_d = (pending_q & ~clr) | bus.req;
   end

   // Grant FSM: latch a selection in IDLE, hold it in PRESENT until ack.
   always_comb begin
      state_d      = state_q;
      out_idx_d    = out_idx_q;
      out_onehot_d = out_onehot_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d      = PRESENT;
               out_idx_d    = sel_idx;
               out_onehot_d = idx_to_onehot(sel_idx);
            end
         end
         PRESENT: begin
            if (bus.ack) begin
               state_d      = IDLE;
               out_onehot_d = '0;
            end
         end
         default: begin
            state_d      = IDLE;
            out_onehot_d = '0;
         end
      endcase
   end

   // State, pending and grant registers; reset drops any grant in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pending_q    <= '0;
         out_idx_q    <= '0;
         out_onehot_q <= '0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         out_idx_q    <= out_idx_d;
         out_onehot_q <= out_onehot_d;
      end
   end

   assign bus.out_valid  = out_valid;
   assign bus.out_idx    = out_idx_q;
   assign bus.out_onehot = out_onehot_q;
   assign bus.pending    = pending_q;

endmodule
